param_commit: RTL and testbench

- Sits between the UART control/register block and the pulse generator.
- Captures each new parameter set on `rx_done` and checks it for timing sanity.
- Holds a valid set pending and commits it atomically at the next pulse-period boundary, so the generator never sees a mid-period parameter change.
- Owns the period counter and produces the period-start strobe.

---
 rtl/pulse_param_pkg.sv | 23 ++
 rtl/period_counter.sv | 36 +++
 rtl/param_commit.sv | 160 ++++++++++++++++
 tb/tb_param_commit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_param_pkg.sv
// Shared constants, FSM state type and sum-width helper for the parameter commit path.
// Optional feature macro used by the top: PARAM_FORCE_EN.
package pulse_param_pkg;

    localparam int PKG_PER_W   = 32;
    localparam int PKG_WID_W   = 16;
    localparam int PKG_DEF_PER = 200000;
    localparam int PKG_MIN_PER = 4;

    // Two guard bits so the sum of three WID_W terms can never overflow.
    localparam int SUM_GUARD_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    function automatic int sum_width(input int wid_w);
        return wid_w + SUM_GUARD_W;
    endfunction

endpackage

// File: rtl/period_counter.sv
// Free-running period counter: counts 0..per-1, flags the last count (wrap)
// and emits a registered one-cycle strobe for every count-0 cycle.
module period_counter
    import pulse_param_pkg::*;
#(
    parameter int PER_W = PKG_PER_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [PER_W-1:0] per,
    input  logic             restart,
    output logic             wrap,
    output logic             cyc_start
);

    logic [PER_W-1:0] r_cnt;
    logic             r_cyc_start;

    assign wrap      = (r_cnt == per - PER_W'(1));
    assign cyc_start = r_cyc_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_cyc_start <= 1'b0;
        end else if (restart) begin
            // The restart cycle itself plays the role of count 0.
            r_cnt       <= PER_W'(1);
            r_cyc_start <= 1'b1;
        end else begin
            r_cyc_start <= (r_cnt == '0);
            r_cnt       <= wrap ? '0 : r_cnt + PER_W'(1);
        end
    end

endmodule

// File: rtl/param_commit.sv
// Captures parameter sets from the register block, sanity-checks them and commits
// them atomically at a period boundary. Define PARAM_FORCE_EN to add force_commit.
module param_commit
    import pulse_param_pkg::*;
#(
    parameter int PER_W   = PKG_PER_W,
    parameter int WID_W   = PKG_WID_W,
    parameter int DEF_PER = PKG_DEF_PER,
    parameter int MIN_PER = PKG_MIN_PER
) (
    input  logic             clk,
    input  logic             resetn,
`ifdef PARAM_FORCE_EN
    input  logic             force_commit,
`endif
    input  logic             rx_done,
    input  logic [PER_W-1:0] per_in,
    input  logic [WID_W-1:0] p1wid_in,
    input  logic [WID_W-1:0] del_in,
    input  logic [WID_W-1:0] p2wid_in,
    input  logic             cp_in,
    input  logic             bl_in,
    input  logic             err_clr,
    output logic [PER_W-1:0] per,
    output logic [WID_W-1:0] p1wid,
    output logic [WID_W-1:0] del,
    output logic [WID_W-1:0] p2wid,
    output logic             cp,
    output logic             bl,
    output logic             cyc_start,
    output logic             pending,
    output logic             err,
    output logic [7:0]       commit_cnt
);

    localparam int SUM_W = sum_width(WID_W);

    state_t           r_state;
    logic [PER_W-1:0] r_per,   r_per_sh;
    logic [WID_W-1:0] r_p1wid, r_p1_sh;
    logic [WID_W-1:0] r_del,   r_del_sh;
    logic [WID_W-1:0] r_p2wid, r_p2_sh;
    logic             r_cp,    r_cp_sh;
    logic             r_bl,    r_bl_sh;
    logic             r_pending;
    logic             r_err;
    logic [7:0]       r_commit_cnt;

    logic [SUM_W-1:0] w_sum;
    logic [PER_W-1:0] w_sum_ext;
    logic             w_valid;
    logic             w_wrap;
    logic             w_restart;
    logic             w_commit;

    assign w_sum     = SUM_W'(r_p1_sh) + SUM_W'(r_del_sh) + SUM_W'(r_p2_sh);
    assign w_sum_ext = PER_W'(w_sum);
    assign w_valid   = (r_per_sh >= PER_W'(MIN_PER)) && (w_sum_ext < r_per_sh);

    // A fresh capture always beats a commit on the same cycle.
`ifdef PARAM_FORCE_EN
    logic w_force;
    assign w_force   = force_commit && (r_state == ST_PENDING) && !rx_done;
    assign w_restart = w_force;
    assign w_commit  = (r_state == ST_PENDING) && !rx_done && (w_wrap || w_force);
`else
    assign w_restart = 1'b0;
    assign w_commit  = (r_state == ST_PENDING) && !rx_done && w_wrap;
`endif

    period_counter #(
        .PER_W     (PER_W)
    ) u_period_counter (
        .clk       (clk),
        .resetn    (resetn),
        .per       (r_per),
        .restart   (w_restart),
        .wrap      (w_wrap),
        .cyc_start (cyc_start)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_per        <= PER_W'(DEF_PER);
            r_p1wid      <= '0;
            r_del        <= '0;
            r_p2wid      <= '0;
            r_cp         <= 1'b0;
            r_bl         <= 1'b1;
            r_per_sh     <= '0;
            r_p1_sh      <= '0;
            r_del_sh     <= '0;
            r_p2_sh      <= '0;
            r_cp_sh      <= 1'b0;
            r_bl_sh      <= 1'b0;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
            r_commit_cnt <= '0;
        end else begin
            // Rejection below is assigned later, so it overrides a same-cycle clear.
            if (err_clr) begin
                r_err <= 1'b0;
            end
            if (rx_done) begin
                r_per_sh  <= per_in;
                r_p1_sh   <= p1wid_in;
                r_del_sh  <= del_in;
                r_p2_sh   <= p2wid_in;
                r_cp_sh   <= cp_in;
                r_bl_sh   <= bl_in;
                r_pending <= 1'b0;
                r_state   <= ST_CHECK;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_CHECK: begin
                        if (w_valid) begin
                            r_pending <= 1'b1;
                            r_state   <= ST_PENDING;
                        end else begin
                            r_err     <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_PENDING: begin
                        if (w_commit) begin
                            r_per        <= r_per_sh;
                            r_p1wid      <= r_p1_sh;
                            r_del        <= r_del_sh;
                            r_p2wid      <= r_p2_sh;
                            r_cp         <= r_cp_sh;
                            r_bl         <= r_bl_sh;
                            r_commit_cnt <= r_commit_cnt + 8'd1;
                            r_pending    <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_pending <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign per        = r_per;
    assign p1wid      = r_p1wid;
    assign del        = r_del;
    assign p2wid      = r_p2wid;
    assign cp         = r_cp;
    assign bl         = r_bl;
    assign pending    = r_pending;
    assign err        = r_err;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_param_commit.sv
// Self-checking bench for param_commit: directed and random parameter sets compared
// every cycle against an event-level reference model (period boundaries as cycle numbers).
module tb_param_commit;

    localparam int PER_W      = 32;
    localparam int WID_W      = 16;
    localparam int TB_DEF_PER = 64;
    localparam int TB_MIN_PER = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             rx_done;
    logic [PER_W-1:0] per_in;
    logic [WID_W-1:0] p1wid_in, del_in, p2wid_in;
    logic             cp_in, bl_in, err_clr;
    logic [PER_W-1:0] per;
    logic [WID_W-1:0] p1wid, del, p2wid;
    logic             cp, bl, cyc_start, pending, err;
    logic [7:0]       commit_cnt;
`ifdef PARAM_FORCE_EN
    logic             force_commit = 1'b0;
`endif

    always #5 clk = ~clk;

    param_commit #(
        .PER_W   (PER_W),
        .WID_W   (WID_W),
        .DEF_PER (TB_DEF_PER),
        .MIN_PER (TB_MIN_PER)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef PARAM_FORCE_EN
        .force_commit (force_commit),
`endif
        .rx_done    (rx_done),
        .per_in     (per_in),
        .p1wid_in   (p1wid_in),
        .del_in     (del_in),
        .p2wid_in   (p2wid_in),
        .cp_in      (cp_in),
        .bl_in      (bl_in),
        .err_clr    (err_clr),
        .per        (per),
        .p1wid      (p1wid),
        .del        (del),
        .p2wid      (p2wid),
        .cp         (cp),
        .bl         (bl),
        .cyc_start  (cyc_start),
        .pending    (pending),
        .err        (err),
        .commit_cnt (commit_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: committed set, candidate set, and cycle numbers of events.
    longint cyc;
    longint m_per, m_p1, m_del, m_p2;
    bit     m_cp, m_bl, m_err;
    int     m_cnt;
    bit     has_cand;
    longint c_per, c_p1, c_del, c_p2;
    bit     c_cp, c_bl;
    longint cand_ready;   // first cycle in which the candidate may be pending
    longint wrap_c;       // cycle whose end is the next period boundary
    longint strobe_c;     // cycle in which cyc_start is expected high

    function automatic bit set_ok(longint p, longint a, longint b, longint d);
        return (p >= TB_MIN_PER) && ((a + b + d) < p);
    endfunction

    task automatic model_reset();
        m_per = TB_DEF_PER; m_p1 = 0; m_del = 0; m_p2 = 0;
        m_cp = 0; m_bl = 1; m_err = 0; m_cnt = 0;
        has_cand = 0; cand_ready = 0;
        wrap_c = TB_DEF_PER - 1;
        strobe_c = 1;
        cyc = 0;
    endtask

    task automatic model_edge();
        bit rej, com;
        rej = 0; com = 0;
        if (rx_done) begin
            c_per = longint'(per_in); c_p1 = longint'(p1wid_in);
            c_del = longint'(del_in); c_p2 = longint'(p2wid_in);
            c_cp = cp_in; c_bl = bl_in;
            has_cand = 1; cand_ready = cyc + 2;
        end else if (has_cand && cyc == cand_ready - 1) begin
            if (!set_ok(c_per, c_p1, c_del, c_p2)) begin
                rej = 1; has_cand = 0;
            end
        end else if (has_cand && cyc >= cand_ready && cyc == wrap_c) begin
            com = 1;
        end
        if (err_clr) m_err = 0;
        if (rej) m_err = 1;
        if (com) begin
            m_per = c_per; m_p1 = c_p1; m_del = c_del; m_p2 = c_p2;
            m_cp = c_cp; m_bl = c_bl;
            m_cnt = (m_cnt + 1) % 256;
            has_cand = 0;
        end
        if (cyc == wrap_c) begin
            strobe_c = cyc + 2;
            wrap_c   = cyc + m_per;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("per",        per,                      32'(m_per));
        chk("p1wid",      32'(p1wid),               32'(m_p1));
        chk("del",        32'(del),                 32'(m_del));
        chk("p2wid",      32'(p2wid),               32'(m_p2));
        chk("cp",         32'(cp),                  32'(m_cp));
        chk("bl",         32'(bl),                  32'(m_bl));
        chk("cyc_start",  32'(cyc_start),           32'(cyc == strobe_c));
        chk("pending",    32'(pending),             32'(has_cand && cyc >= cand_ready));
        chk("err",        32'(err),                 32'(m_err));
        chk("commit_cnt", 32'(commit_cnt),          32'(m_cnt));
    endtask

    // Check this cycle, apply the model edge, advance one clock.
    task automatic tick();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        rx_done = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int p, input int a, input int b, input int d,
                        input bit c, input bit bk);
        per_in   = PER_W'(p);
        p1wid_in = WID_W'(a);
        del_in   = WID_W'(b);
        p2wid_in = WID_W'(d);
        cp_in    = c;
        bl_in    = bk;
        rx_done  = 1'b1;
        tick();
    endtask

    initial begin
        resetn = 1'b0; rx_done = 1'b0; err_clr = 1'b0;
        per_in = '0; p1wid_in = '0; del_in = '0; p2wid_in = '0;
        cp_in = 1'b0; bl_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        // rx_done while held in reset must be ignored
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        rx_done = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Default period: strobes at cycle 1, 65, 129
        idle(2 * TB_DEF_PER + 4);

        // Valid set mid-period
        idle(10);
        send(100, 10, 20, 10, 1'b1, 1'b0);
        idle(250);

        // Invalid set, then clear
        send(30, 10, 20, 10, 1'b0, 1'b1);
        idle(6);
        err_clr = 1'b1;
        tick();
        idle(3);

        // Two captures while pending: only the latest commits
        send(100, 5, 5, 5, 1'b0, 1'b0);
        idle(3);
        send(60, 5, 5, 5, 1'b1, 1'b1);
        idle(220);

        // Boundaries: smallest valid period, sum == per, per below minimum
        send(4, 1, 1, 1, 1'b0, 1'b0);
        idle(20);
        send(50, 20, 20, 10, 1'b1, 1'b1);
        idle(4);
        send(3, 0, 0, 0, 1'b0, 1'b0);
        idle(2);

        // err_clr on the same cycle as a new rejection: set wins
        send(10, 5, 5, 0, 1'b0, 1'b0);
        err_clr = 1'b1;
        tick();
        idle(3);
        err_clr = 1'b1;
        tick();

        // Capture arriving on the wrap cycle of a pending set
        send(40, 1, 1, 1, 1'b1, 1'b0);
        idle(2);
        while (cyc != wrap_c) tick();
        send(24, 2, 2, 2, 1'b0, 1'b1);
        idle(100);

        // Many commits to take commit_cnt through 255 -> 0
        for (int i = 0; i < 260; i++) begin
            send(4 + (i % 3), 1, 1, i % 2, i[0], i[1]);
            idle(8);
        end

        // Random sets, gaps and error clears
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(90, 0)), int'($urandom_range(40, 0)),
                 int'($urandom_range(40, 0)), int'($urandom_range(40, 0)),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int j = int'($urandom_range(120, 0)); j > 0; j--) begin
                err_clr = ($urandom_range(7, 0) == 0);
                tick();
            end
        end

        // Reset while a set is pending: set is discarded
        send(100, 1, 1, 1, 1'b1, 1'b0);
        idle(3);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
        idle(2 * TB_DEF_PER + 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
